// File: rtl/mem_writeback_if.sv
// Execute-side, data-memory and register-file signals of the writeback block.
// master: the mem_writeback block itself; slave: its environment (execute stage, memory, register file).
interface mem_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] mem_address;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;
  logic        timeout_err;

  modport master (
    input  in_valid, is_load, is_store, funct3, rd, mem_address, store_data,
    input  mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output rf_we, rf_waddr, rf_wdata, misalign_err, timeout_err
  );

  modport slave (
    output in_valid, is_load, is_store, funct3, rd, mem_address, store_data,
    output mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  rf_we, rf_waddr, rf_wdata, misalign_err, timeout_err
  );
endinterface

// File: rtl/mem_writeback.sv
// Memory-access / writeback stage: IDLE -> ACCESS -> WB FSM with byte-lane store/load alignment.
// Optional MEMWB_TIMEOUT_EN: abandon an unacknowledged access after 255 waiting cycles.
module mem_writeback (
  input  logic            clk,
  input  logic            rst,
  mem_writeback_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  state_t      state, state_nxt;
  logic        accept, is_mem, misalign, timeout_hit, ack_hit;
  logic [31:0] addr_p1, wdata_p1, wb_data_p1;
  logic [3:0]  wstrb_p1;
  logic [2:0]  f3_p1;
  logic [1:0]  off_p1;
  logic [4:0]  rd_p1;
  logic        we_p1, load_p1, mis_p1;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || (f3[1] && (off != 2'b00));
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // funct3[2] selects zero extension (LBU/LHU); otherwise the top bit of the lane is replicated.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign bus.in_ready = (state == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_mem       = bus.is_load || bus.is_store;
  assign misalign     = misaligned(bus.funct3, bus.mem_address[1:0]);

`ifdef MEMWB_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Counter rests at zero outside ACCESS, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (rst)                                to_cnt <= 8'd0;
    else if (state != ACCESS)               to_cnt <= 8'd0;
    else if (!bus.mem_ack && to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
  end

  assign timeout_hit     = (state == ACCESS) && (to_cnt == 8'hFF);
  assign bus.timeout_err = timeout_hit && !rst;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign ack_hit = (state == ACCESS) && bus.mem_ack && !timeout_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_mem)       state_nxt = WB;
          else if (misalign) state_nxt = IDLE;
          else               state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (timeout_hit)  state_nxt = IDLE;
        else if (ack_hit) state_nxt = load_p1 ? WB : IDLE;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: operation captured at accept; load data folded into wb_data_p1 on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_p1    <= 32'd0;
      wdata_p1   <= 32'd0;
      wstrb_p1   <= 4'd0;
      wb_data_p1 <= 32'd0;
      f3_p1      <= 3'd0;
      off_p1     <= 2'd0;
      rd_p1      <= 5'd0;
      we_p1      <= 1'b0;
      load_p1    <= 1'b0;
      mis_p1     <= 1'b0;
    end else begin
      state  <= state_nxt;
      mis_p1 <= accept && is_mem && misalign;
      if (accept) begin
        addr_p1    <= {bus.mem_address[31:2], 2'b00};
        wdata_p1   <= bus.is_store ? store_lanes(bus.funct3, bus.store_data) : 32'd0;
        wstrb_p1   <= bus.is_store ? store_strobe(bus.funct3, bus.mem_address[1:0]) : 4'd0;
        wb_data_p1 <= bus.store_data;
        f3_p1      <= bus.funct3;
        off_p1     <= bus.mem_address[1:0];
        rd_p1      <= bus.rd;
        we_p1      <= bus.is_store;
        load_p1    <= bus.is_load && !bus.is_store;
      end else if (ack_hit && load_p1) begin
        wb_data_p1 <= load_extract(f3_p1, off_p1, bus.mem_rdata);
      end
    end
  end

  // Outputs are gated by rst so they read zero for the whole reset cycle, not only after it.
  assign bus.mem_req      = (state == ACCESS) && !rst && !timeout_hit;
  assign bus.mem_we       = bus.mem_req && we_p1;
  assign bus.mem_wstrb    = bus.mem_req ? wstrb_p1 : 4'd0;
  assign bus.mem_addr     = rst ? 32'd0 : addr_p1;
  assign bus.mem_wdata    = rst ? 32'd0 : wdata_p1;
  assign bus.rf_we        = (state == WB) && !rst && (rd_p1 != 5'd0);
  assign bus.rf_waddr     = rst ? 5'd0 : rd_p1;
  assign bus.rf_wdata     = rst ? 32'd0 : wb_data_p1;
  assign bus.misalign_err = mis_p1 && !rst;
endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  in  1  system clock
REQ-003 rst  in  1  synchronous active-high reset
REQ-004 in_valid  in  1  execute-stage result valid
REQ-005 in_ready  out  1  block can accept a result this cycle
REQ-006 is_load, is_store  in  1 each  memory op type; both low means ALU/immediate writeback only
REQ-007 funct3  in  3  access width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use 000/001/010)
REQ-008 rd  in  5  destination register
REQ-009 mem_address  in  32  effective byte address from execute
REQ-010 store_data  in  32  ALU result, or store data when is_store
REQ-011 mem_req, mem_we  out  1 each  data-memory request and write enable
REQ-012 mem_addr  out  32  word-aligned address ({mem_address[31:2],2'b00})
REQ-013 mem_wdata, mem_wstrb  out  32, 4  lane-shifted write data and byte strobes
REQ-014 mem_rdata, mem_ack  in  32, 1  read data, valid with mem_ack
REQ-015 rf_we, rf_waddr, rf_wdata  out  1, 5, 32  register-file write port
REQ-016 misalign_err, timeout_err  out  1 each  one-cycle error pulses

Function
REQ-017 States SHALL be IDLE, ACCESS and WB.
REQ-018 in_ready SHALL be 1 only in IDLE; a transfer SHALL occur when in_valid and in_ready are both 1, and all inputs SHALL be captured on that edge.
REQ-019 Non-memory result: IDLE->WB; next cycle rf_we=1 with rf_wdata=store_data; then WB->IDLE. Latency is 1 cycle.
REQ-020 Load or store, aligned: IDLE->ACCESS; mem_req=1 on the cycle after accept and held with constant address, data and strobes until the cycle mem_ack=1.
REQ-021 A store SHALL set mem_we=1; byte strobe is 1<<addr[1:0] and halfword strobe is 0011 or 1100; mem_wdata SHALL be the data replicated into the selected lanes; on ack the FSM SHALL go ACCESS->IDLE with no rf write.
REQ-022 A load SHALL capture mem_rdata on ack and go ACCESS->WB; in WB, rf_wdata SHALL be the selected byte/halfword shifted by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU), or the full word (LW).
REQ-023 Load latency SHALL be N+1 cycles after accept, where N>=1 is the number of cycles until mem_ack.
REQ-024 Misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL issue no mem_req and no rf write; misalign_err SHALL pulse for 1 cycle and the FSM SHALL return to IDLE.
REQ-025 rf_we SHALL be suppressed when rd==0, while WB timing is unchanged.
REQ-026 mem_ack outside ACCESS SHALL be ignored.
REQ-027 rf_we SHALL be high for exactly one cycle per writeback, and rf_waddr SHALL equal the captured rd.

Reset
REQ-028 Reset SHALL force state to IDLE and clear every captured register.
REQ-029 During reset, mem_req, mem_we, mem_wstrb, rf_we, misalign_err and timeout_err SHALL be 0; mem_addr, mem_wdata, rf_waddr and rf_wdata SHALL be 0; in_ready SHALL be 0.
REQ-030 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-031 Reset asserted in ACCESS SHALL drop mem_req in the same cycle reset is sampled; a later ack for that request SHALL be ignored.

Configuration
REQ-032 Macro MEMWB_TIMEOUT_EN: when defined, an 8-bit counter SHALL clear on entry to ACCESS and count each cycle without ack; at 255, the block SHALL drop mem_req, pulse timeout_err, skip writeback and return to IDLE.
REQ-033 Without MEMWB_TIMEOUT_EN, ACCESS SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-034 ALU writeback: rd=5, store_data=0x12345678, no mem op -> rf_we=1, rf_waddr=5, rf_wdata=0x12345678 one cycle after accept.
REQ-035 Store byte: mem_address=0x103, store_data=0xAB, funct3=000 -> mem_addr=0x100, mem_wstrb=1000, mem_wdata[31:24]=0xAB; held through a 3-cycle ack delay; no rf_we.
REQ-036 Load LB/LBU: mem_address=0x201, mem_rdata=0x0000F000 -> LB gives rf_wdata=0xFFFFFFF0; LBU gives 0x000000F0.
REQ-037 Misaligned LW at 0x202 -> misalign_err pulse, no mem_req, no rf_we, in_ready=1 next cycle.
REQ-038 Load to rd=0 -> memory access occurs, rf_we stays 0.
REQ-039 Reset mid-ACCESS followed by a late ack -> no rf_we, state IDLE; with MEMWB_TIMEOUT_EN and ack never given -> timeout_err on cycle 255 of ACCESS.
